mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- Memory-stage controller between the EX/MEM and MEM/WB pipeline registers.
- Consumes the EX/MEM fields MemRead, MemWrite, func3, Alu_Result (address) and RD_Two (store data), and drives a handshaked data memory.
- Produces the sign/zero-extended MemReadData for MEM/WB.
- Holds a global stall while an access is outstanding; reports misaligned accesses and response timeouts.

Parameters:
- TIMEOUT_CYCLES, 16, max cycles waiting for dmem_rvalid after grant before aborting the load (≥2).
- ADDR_W, 9, data-memory byte-address width (matches the 9-bit PC/address space).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- exm_mem_read  in  1  EX/MEM MemRead.
- exm_mem_write  in  1  EX/MEM MemWrite (never asserted together with MemRead).
- exm_func3  in  3  EX/MEM func3; selects access size/sign.
- exm_addr  in  32  EX/MEM Alu_Result; only [ADDR_W-1:0] used.
- exm_wdata  in  32  EX/MEM RD_Two.
- dmem_req  out  1  request valid.
- dmem_we  out  1  1 = store, 0 = load.
- dmem_addr  out  ADDR_W  word-aligned address (low 2 bits forced 0).
- dmem_be  out  4  byte enables.
- dmem_wdata  out  32  lane-shifted store data.
- dmem_gnt  in  1  request accepted this cycle.
- dmem_rvalid  in  1  read data valid.
- dmem_rdata  in  32  read word.
- mem_stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM; insert bubble into MEM/WB.
- load_data  out  32  extended load result for MEM/WB MemReadData.
- misalign_err  out  1  one-cycle pulse: misaligned access suppressed.
- timeout_err  out  1  one-cycle pulse: load aborted on timeout.

Behaviour:
- Reset state: IDLE; all outputs 0; timeout counter 0.
- Access sizes from func3:
  - 000 LB/SB, 100 LBU: byte.
  - 001 LH/SH, 101 LHU: half.
  - 010 LW/SW: word.
  - Other func3 with read/write asserted is treated as word.
- Alignment:
  - Half requires addr[0]=0.
  - Word requires addr[1:0]=00.
- Store encoding:
  - be = 0001<<addr[1:0] for byte, 0011<<addr[1:0] for half, 1111 for word.
  - wdata = replicated byte or half (byte: {4{b}}, half: {2{h}}).
- Load encoding:
  - Byte/half selected from dmem_rdata by addr[1:0].
  - Sign-extended for LB/LH; zero-extended for LBU/LHU.
  - dmem_be = access mask for loads too.
- FSM states: IDLE, REQ, WAIT, DONE.
  - IDLE, no access (read=write=0): stay; mem_stall=0.
  - IDLE, access misaligned: stay; no request; misalign_err=1 this cycle; mem_stall=0 (instruction completes with load_data unchanged).
  - IDLE, aligned access: mem_stall=1 combinationally; dmem_req/we/addr/be/wdata registered; go REQ next cycle.
  - REQ: dmem_req=1 and all request fields held stable until dmem_gnt.
    - gnt with store → DONE.
    - gnt with load → WAIT, counter cleared.
  - WAIT: dmem_req=0; counter increments each cycle.
    - dmem_rvalid → load_data <= extended data; go DONE.
    - Counter reaches TIMEOUT_CYCLES-1 without rvalid → load_data <= 0; timeout_err pulse; go DONE.
  - DONE: mem_stall=0 for exactly one cycle (pipeline advances); load_data valid; go IDLE.
    - Next cycle sees the new EX/MEM contents, so there is no re-issue of the same access.
- mem_stall = (IDLE & aligned access) | REQ | WAIT.
- Minimum latency: zero-wait memory (gnt in REQ, rvalid the next cycle) gives a load 3 stall cycles.
  - Latency is 2 for a store granted immediately.
- rvalid in the same cycle as gnt is not accepted; rvalid is only sampled in WAIT.
- rvalid arriving in IDLE, REQ or DONE is ignored.
- load_data holds its value between loads; stores do not modify it.
- Reset mid-access (any state): immediate return to IDLE, dmem_req=0, stall released; later responses ignored.

Test Plan:
- LW addr=0x010, gnt in first REQ cycle, rvalid next cycle with rdata=0xDEADBEEF → dmem_addr=0x010, be=1111; mem_stall high 3 cycles; load_data=0xDEADBEEF in DONE.
- LB addr=0x013, rdata=0x80FF7F01 → be=1000, load_data=0xFFFFFF80; LBU same address → 0x00000080; LH addr=0x002 → 0xFFFF80FF.
- SH addr=0x006, wdata=0x1234ABCD, gnt delayed 3 cycles → REQ fields stable 4 cycles; be=1100, dmem_wdata=0xABCDABCD, we=1; load_data unchanged.
- LW addr=0x005 → misalign_err pulse 1 cycle; dmem_req never asserted; mem_stall stays 0.
- LW granted, rvalid never asserted, TIMEOUT_CYCLES=16 → timeout_err after 16 WAIT cycles; load_data=0; FSM reaches IDLE.
- Assert reset while in WAIT → dmem_req, mem_stall, load_data read 0 asynchronously; a later rvalid is ignored; the next LW completes normally.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Memory-stage controller: turns EX/MEM load/store fields into a handshaked
// data-memory access, stalls the pipeline while it is outstanding and returns
// the sign/zero-extended load result for MEM/WB.
module mem_access_ctrl #(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int ADDR_W         = 9
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              exm_mem_read,
   input  logic              exm_mem_write,
   input  logic [2:0]        exm_func3,
   input  logic [31:0]       exm_addr,
   input  logic [31:0]       exm_wdata,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [3:0]        dmem_be,
   output logic [31:0]       dmem_wdata,
   input  logic              dmem_gnt,
   input  logic              dmem_rvalid,
   input  logic [31:0]       dmem_rdata,
   output logic              mem_stall,
   output logic [31:0]       load_data,
   output logic              misalign_err,
   output logic              timeout_err
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

   state_t              state_q;
   logic                req_q;
   logic                we_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [3:0]          be_q;
   logic [31:0]         wdata_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [31:0]         load_q;
   logic                timeout_q;
   logic [2:0]          func3_q;
   logic [1:0]          off_q;

   logic                is_byte;
   logic                is_half;
   logic                access;
   logic                aligned;
   logic [3:0]          be_d;
   logic [31:0]         wdata_d;
   logic [31:0]         ext_d;
   logic [7:0]          byte_sel;
   logic [15:0]         half_sel;
   logic                addr_unused;

   // Only the low ADDR_W address bits reach the data memory.
   assign addr_unused = ^exm_addr[31:ADDR_W];

   // Access size from func3[1:0]: 00 byte, 01 half, anything else is a word.
   assign is_byte = (exm_func3[1:0] == 2'b00);
   assign is_half = (exm_func3[1:0] == 2'b01);
   assign access  = exm_mem_read | exm_mem_write;
   assign aligned = is_byte ? 1'b1 :
                    is_half ? ~exm_addr[0] : (exm_addr[1:0] == 2'b00);

   // Byte-enable mask and lane-replicated store data for the issuing access.
   always_comb begin
      be_d    = 4'b1111;
      wdata_d = exm_wdata;
      if (is_byte) begin
         be_d    = 4'b0001 << exm_addr[1:0];
         wdata_d = {4{exm_wdata[7:0]}};
      end else if (is_half) begin
         be_d    = 4'b0011 << exm_addr[1:0];
         wdata_d = {2{exm_wdata[15:0]}};
      end
   end

   // Extract and extend the addressed lane of the returned read word.
   always_comb begin
      byte_sel = dmem_rdata[{off_q, 3'b000} +: 8];
      half_sel = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
      case (func3_q)
         3'b000:  ext_d = {{24{byte_sel[7]}}, byte_sel};
         3'b100:  ext_d = {24'd0, byte_sel};
         3'b001:  ext_d = {{16{half_sel[15]}}, half_sel};
         3'b101:  ext_d = {16'd0, half_sel};
         default: ext_d = dmem_rdata;
      endcase
   end

   // Access FSM with registered request fields, load result and timeout pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         req_q     <= 1'b0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         be_q      <= 4'b0000;
         wdata_q   <= 32'd0;
         cnt_q     <= '0;
         load_q    <= 32'd0;
         timeout_q <= 1'b0;
         func3_q   <= 3'b000;
         off_q     <= 2'b00;
      end else begin
         timeout_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (access && aligned) begin
                  state_q <= REQ;
                  req_q   <= 1'b1;
                  we_q    <= exm_mem_write;
                  addr_q  <= {exm_addr[ADDR_W-1:2], 2'b00};
                  be_q    <= be_d;
                  wdata_q <= wdata_d;
                  func3_q <= exm_func3;
                  off_q   <= exm_addr[1:0];
               end
            end
            REQ: begin
               if (dmem_gnt) begin
                  req_q <= 1'b0;
                  if (we_q) begin
                     state_q <= DONE;
                  end else begin
                     state_q <= WAIT;
                     cnt_q   <= '0;
                  end
               end
            end
            WAIT: begin
               cnt_q <= cnt_q + 1'b1;
               if (dmem_rvalid) begin
                  load_q  <= ext_d;
                  state_q <= DONE;
               end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                  load_q    <= 32'd0;
                  timeout_q <= 1'b1;
                  state_q   <= DONE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // Stall and misalignment are combinational so the issuing cycle is covered;
   // both are forced low while reset is held so the pipeline is released.
   assign mem_stall    = ~reset & (((state_q == IDLE) & access & aligned) |
                                   (state_q == REQ) | (state_q == WAIT));
   assign misalign_err = ~reset & (state_q == IDLE) & access & ~aligned;

   assign dmem_req    = req_q;
   assign dmem_we     = we_q;
   assign dmem_addr   = addr_q;
   assign dmem_be     = be_q;
   assign dmem_wdata  = wdata_q;
   assign load_data   = load_q;
   assign timeout_err = timeout_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: a table of load/store vectors served by
// a simple in-bench memory responder, plus hand-written misalign, timeout and
// reset-during-wait sequences.
module tb_mem_access_ctrl;

   logic        clk;
   logic        reset;
   logic        exm_mem_read;
   logic        exm_mem_write;
   logic [2:0]  exm_func3;
   logic [31:0] exm_addr;
   logic [31:0] exm_wdata;
   logic        dmem_req;
   logic        dmem_we;
   logic [8:0]  dmem_addr;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_wdata;
   logic        dmem_gnt;
   logic        dmem_rvalid;
   logic [31:0] dmem_rdata;
   logic        mem_stall;
   logic [31:0] load_data;
   logic        misalign_err;
   logic        timeout_err;

   int n_assert = 0;
   int n_fail   = 0;

   mem_access_ctrl #(.TIMEOUT_CYCLES(16), .ADDR_W(9)) dut (
      .clk          (clk),
      .reset        (reset),
      .exm_mem_read (exm_mem_read),
      .exm_mem_write(exm_mem_write),
      .exm_func3    (exm_func3),
      .exm_addr     (exm_addr),
      .exm_wdata    (exm_wdata),
      .dmem_req     (dmem_req),
      .dmem_we      (dmem_we),
      .dmem_addr    (dmem_addr),
      .dmem_be      (dmem_be),
      .dmem_wdata   (dmem_wdata),
      .dmem_gnt     (dmem_gnt),
      .dmem_rvalid  (dmem_rvalid),
      .dmem_rdata   (dmem_rdata),
      .mem_stall    (mem_stall),
      .load_data    (load_data),
      .misalign_err (misalign_err),
      .timeout_err  (timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          gnt_dly;
      logic [31:0] e_addr;
      logic [31:0] e_be;
      logic [31:0] e_wdata;
      logic [31:0] e_load;
   } vec_t;

   vec_t vecs[11];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Issue one access and serve it: gnt after gnt_dly REQ cycles, rvalid the
   // cycle after gnt for loads. Checks request fields, stall length, result.
   task automatic run_vec(input int idx, input vec_t v);
      int stalls, req_cycles, cyc;
      bit done, rv_next;
      stalls = 0; req_cycles = 0; cyc = 0; done = 0; rv_next = 0;
      @(negedge clk);
      exm_mem_read  = v.rd;
      exm_mem_write = v.wr;
      exm_func3     = v.f3;
      exm_addr      = v.addr;
      exm_wdata     = v.wdata;
      dmem_rdata    = v.rdata;
      dmem_gnt      = 1'b0;
      dmem_rvalid   = 1'b0;
      while (!done && cyc < 64) begin
         #1;
         dmem_rvalid = rv_next;
         rv_next     = 1'b0;
         if (mem_stall) stalls++;
         if (dmem_req) begin
            req_cycles++;
            chk("req_addr", 32'(dmem_addr), v.e_addr);
            chk("req_be",   32'(dmem_be),   v.e_be);
            chk("req_we",   32'(dmem_we),   32'(v.wr));
            if (v.wr) chk("req_wdata", dmem_wdata, v.e_wdata);
            if (req_cycles > v.gnt_dly) begin
               dmem_gnt = 1'b1;
               rv_next  = v.rd;
            end else begin
               dmem_gnt = 1'b0;
            end
         end else begin
            dmem_gnt = 1'b0;
            if (req_cycles > 0 && !mem_stall) begin
               done = 1'b1;
               chk("stall_cycles", 32'(stalls), 32'((v.rd ? 3 : 2) + v.gnt_dly));
               chk("req_cycles", 32'(req_cycles), 32'(v.gnt_dly + 1));
               chk("load_data", load_data, v.e_load);
               chk("timeout_err", 32'(timeout_err), 32'd0);
               $display("vec %0d: rd=%0d wr=%0d f3=%b addr=%h be=%b load_data=%h stalls=%0d",
                        idx, v.rd, v.wr, v.f3, v.addr, dmem_be, load_data, stalls);
               exm_mem_read  = 1'b0;
               exm_mem_write = 1'b0;
            end
         end
         if (!done) begin
            @(negedge clk);
            cyc++;
         end
      end
      chk("vec_budget", 32'(done), 32'd1);
      dmem_gnt    = 1'b0;
      dmem_rvalid = 1'b0;
   endtask

   initial begin
      int  wait_cycles, cyc;
      bit  granted, done;
      logic [31:0] saved;

      //            rd wr  f3      addr          wdata         rdata         dly e_addr       e_be  e_wdata       e_load
      vecs[0]  = '{1, 0, 3'b010, 32'hFFFFF010, 32'h0,        32'hDEADBEEF, 0, 32'h010, 32'hF, 32'h0,        32'hDEADBEEF};
      vecs[1]  = '{1, 0, 3'b000, 32'h013,      32'h0,        32'h80FF7F01, 0, 32'h010, 32'h8, 32'h0,        32'hFFFFFF80};
      vecs[2]  = '{1, 0, 3'b100, 32'h013,      32'h0,        32'h80FF7F01, 0, 32'h010, 32'h8, 32'h0,        32'h00000080};
      vecs[3]  = '{1, 0, 3'b001, 32'h002,      32'h0,        32'h80FF7F01, 0, 32'h000, 32'hC, 32'h0,        32'hFFFF80FF};
      vecs[4]  = '{0, 1, 3'b001, 32'h006,      32'h1234ABCD, 32'h0,        3, 32'h004, 32'hC, 32'hABCDABCD, 32'hFFFF80FF};
      vecs[5]  = '{0, 1, 3'b000, 32'h00B,      32'h000000A5, 32'h0,        1, 32'h008, 32'h8, 32'hA5A5A5A5, 32'hFFFF80FF};
      vecs[6]  = '{0, 1, 3'b010, 32'h1FC,      32'h01234567, 32'h0,        0, 32'h1FC, 32'hF, 32'h01234567, 32'hFFFF80FF};
      vecs[7]  = '{1, 0, 3'b101, 32'h00E,      32'h0,        32'h80017FFE, 2, 32'h00C, 32'hC, 32'h0,        32'h00008001};
      vecs[8]  = '{1, 0, 3'b001, 32'h000,      32'h0,        32'h00008001, 0, 32'h000, 32'h3, 32'h0,        32'hFFFF8001};
      vecs[9]  = '{1, 0, 3'b000, 32'h011,      32'h0,        32'h12345678, 0, 32'h010, 32'h2, 32'h0,        32'h00000056};
      vecs[10] = '{1, 0, 3'b011, 32'h020,      32'h0,        32'hCAFEF00D, 0, 32'h020, 32'hF, 32'h0,        32'hCAFEF00D};

      reset = 1'b1;
      exm_mem_read = 1'b0; exm_mem_write = 1'b0; exm_func3 = 3'b000;
      exm_addr = 32'd0; exm_wdata = 32'd0;
      dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'd0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk); #1;
      chk("rst_req",      32'(dmem_req),     32'd0);
      chk("rst_stall",    32'(mem_stall),    32'd0);
      chk("rst_load",     load_data,         32'd0);
      chk("rst_be",       32'(dmem_be),      32'd0);
      chk("rst_misalign", 32'(misalign_err), 32'd0);
      chk("rst_timeout",  32'(timeout_err),  32'd0);
      $display("reset: req=%0d stall=%0d load_data=%h", dmem_req, mem_stall, load_data);

      for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

      // Misaligned word load: pulse for one cycle, no request, no stall.
      saved = load_data;
      @(negedge clk);
      exm_mem_read = 1'b1; exm_func3 = 3'b010; exm_addr = 32'h005;
      #1;
      chk("mis_pulse", 32'(misalign_err), 32'd1);
      chk("mis_stall", 32'(mem_stall),    32'd0);
      @(negedge clk);
      exm_mem_read = 1'b0;
      #1;
      chk("mis_pulse_end", 32'(misalign_err), 32'd0);
      chk("mis_no_req",    32'(dmem_req),     32'd0);
      chk("mis_load_hold", load_data,         saved);
      $display("misalign: addr=005 load_data=%h", load_data);

      // Timeout: grant immediately, never return rvalid.
      @(negedge clk);
      exm_mem_read = 1'b1; exm_func3 = 3'b010; exm_addr = 32'h040;
      wait_cycles = 0; granted = 0; done = 0; cyc = 0;
      while (!done && cyc < 64) begin
         #1;
         if (granted && mem_stall && !dmem_req) wait_cycles++;
         if (dmem_req) begin
            dmem_gnt = 1'b1;
            granted  = 1'b1;
         end else begin
            dmem_gnt = 1'b0;
            if (granted && !mem_stall) begin
               done = 1'b1;
               chk("to_wait_cycles", 32'(wait_cycles), 32'd16);
               chk("to_pulse",       32'(timeout_err), 32'd1);
               chk("to_load_zero",   load_data,        32'd0);
               exm_mem_read = 1'b0;
            end
         end
         if (!done) begin
            @(negedge clk);
            cyc++;
         end
      end
      chk("to_budget", 32'(done), 32'd1);
      @(negedge clk); #1;
      chk("to_pulse_end", 32'(timeout_err), 32'd0);
      chk("to_idle_stall", 32'(mem_stall),  32'd0);
      $display("timeout: wait_cycles=%0d load_data=%h", wait_cycles, load_data);

      // Reset while in WAIT; a late rvalid must be ignored.
      run_vec(11, vecs[0]);
      @(negedge clk);
      exm_mem_read = 1'b1; exm_func3 = 3'b010; exm_addr = 32'h060;
      dmem_rdata = 32'h55555555;
      cyc = 0;
      #1;
      while (!dmem_req && cyc < 8) begin
         @(negedge clk); #1;
         cyc++;
      end
      chk("rw_req_seen", 32'(dmem_req), 32'd1);
      dmem_gnt = 1'b1;
      @(negedge clk);
      dmem_gnt = 1'b0;
      #1;
      chk("rw_in_wait", 32'(mem_stall & ~dmem_req), 32'd1);
      reset = 1'b1;
      #1;
      chk("rw_req0",   32'(dmem_req),  32'd0);
      chk("rw_stall0", 32'(mem_stall), 32'd0);
      chk("rw_load0",  load_data,      32'd0);
      @(negedge clk);
      reset = 1'b0;
      exm_mem_read = 1'b0;
      dmem_rvalid = 1'b1;
      @(negedge clk);
      dmem_rvalid = 1'b0;
      #1;
      chk("rw_late_rvalid", load_data,        32'd0);
      chk("rw_stall_after", 32'(mem_stall),   32'd0);
      $display("reset-in-wait: load_data=%h stall=%0d", load_data, mem_stall);
      run_vec(12, vecs[0]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
